// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the pipelined RISC-V control unit: opcodes, control-field
// enums, and the packed control word carried through the pipeline registers.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_t;

  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'b00,
    ALU_A_PC   = 2'b01,
    ALU_A_ZERO = 2'b10
  } alu_a_src_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    res_src_t   result_src;
    alu_a_src_t alu_a_src;
    alu_op_t    alu_op;
  } ctrl_word_t;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    res_src_t result_src;
  } ctrl_mem_t;

  typedef struct packed {
    logic     reg_write;
    res_src_t result_src;
  } ctrl_wb_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder. An undecoded or disabled opcode yields an
// all-zero control word; valid_i=0 also yields zero and never flags illegal.
module ctrl_decode
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_JUMP  = 1'b1,
  parameter bit ENABLE_UPPER = 1'b1
) (
  input  logic       [6:0] op_i,
  input  logic             valid_i,
  output ctrl_word_t       word_o,
  output logic       [2:0] imm_src_o,
  output logic             illegal_o
);

  ctrl_word_t word;
  imm_src_t   imm;
  logic       legal;

  always_comb begin
    word  = '0;
    imm   = IMM_I;
    legal = 1'b1;
    unique case (op_i)
      OP_LOAD: begin
        word.reg_write  = 1'b1;
        word.alu_src    = 1'b1;
        word.result_src = RES_MEM;
      end
      OP_STORE: begin
        word.mem_write = 1'b1;
        word.alu_src   = 1'b1;
        imm            = IMM_S;
      end
      OP_R: begin
        word.reg_write = 1'b1;
        word.alu_op    = ALU_OP_FUNCT;
      end
      OP_IALU: begin
        word.reg_write = 1'b1;
        word.alu_src   = 1'b1;
        word.alu_op    = ALU_OP_FUNCT;
      end
      OP_BRANCH: begin
        word.branch = 1'b1;
        word.alu_op = ALU_OP_SUB;
        imm         = IMM_B;
      end
      OP_JAL: begin
        word.reg_write  = 1'b1;
        word.jump       = 1'b1;
        word.result_src = RES_PC4;
        imm             = IMM_J;
        legal           = ENABLE_JUMP;
      end
      OP_JALR: begin
        word.reg_write  = 1'b1;
        word.jump       = 1'b1;
        word.jalr       = 1'b1;
        word.alu_src    = 1'b1;
        word.result_src = RES_PC4;
        legal           = ENABLE_JUMP;
      end
      OP_LUI: begin
        word.reg_write = 1'b1;
        word.alu_src   = 1'b1;
        word.alu_a_src = ALU_A_ZERO;
        imm            = IMM_U;
        legal          = ENABLE_UPPER;
      end
      OP_AUIPC: begin
        word.reg_write = 1'b1;
        word.alu_src   = 1'b1;
        word.alu_a_src = ALU_A_PC;
        imm            = IMM_U;
        legal          = ENABLE_UPPER;
      end
      default: legal = 1'b0;
    endcase
    // Anything that is not a real, legal instruction becomes a bubble.
    if (!valid_i || !legal) begin
      word = '0;
      imm  = IMM_I;
    end
  end

  assign word_o    = word;
  assign imm_src_o = imm;
  assign illegal_o = valid_i && !legal;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline ID/EX -> EX/MEM -> MEM/WB with hazard stall/flush and a
// saturating count of illegal instructions admitted into EX.
module ctrl_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter bit          ENABLE_JUMP  = 1'b1,
  parameter bit          ENABLE_UPPER = 1'b1,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op_d,
  input  logic             valid_d,
  input  logic             stall_e,
  input  logic             flush_e,
  output logic [2:0]       imm_src_d,
  output logic             illegal_d,
  output logic             reg_write_e,
  output logic             mem_write_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic             jalr_e,
  output logic             alu_src_e,
  output logic [1:0]       result_src_e,
  output logic [1:0]       alu_a_src_e,
  output logic [1:0]       alu_op_e,
  output logic             reg_write_m,
  output logic             mem_write_m,
  output logic [1:0]       result_src_m,
  output logic             reg_write_w,
  output logic [1:0]       result_src_w,
  output logic [CNT_W-1:0] illegal_cnt
);

  ctrl_word_t        dec_word;
  ctrl_word_t        idex_q, idex_d;
  ctrl_mem_t         exmem_q, exmem_d;
  ctrl_wb_t          memwb_q, memwb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              idex_load;

  ctrl_decode #(
    .ENABLE_JUMP  (ENABLE_JUMP),
    .ENABLE_UPPER (ENABLE_UPPER)
  ) u_decode (
    .op_i      (op_d),
    .valid_i   (valid_d),
    .word_o    (dec_word),
    .imm_src_o (imm_src_d),
    .illegal_o (illegal_d)
  );

  assign idex_load = !flush_e && !stall_e;

  always_comb begin
    idex_d = idex_q;
    if (flush_e)        idex_d = '0;
    else if (!stall_e)  idex_d = dec_word;

    // A stall keeps the EX word but must not duplicate it into MEM.
    exmem_d = '0;
    if (!(stall_e && !flush_e)) begin
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.result_src = idex_q.result_src;
    end

    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.result_src = exmem_q.result_src;

    cnt_d = cnt_q;
    if (illegal_d && idex_load && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign reg_write_e  = idex_q.reg_write;
  assign mem_write_e  = idex_q.mem_write;
  assign branch_e     = idex_q.branch;
  assign jump_e       = idex_q.jump;
  assign jalr_e       = idex_q.jalr;
  assign alu_src_e    = idex_q.alu_src;
  assign result_src_e = idex_q.result_src;
  assign alu_a_src_e  = idex_q.alu_a_src;
  assign alu_op_e     = idex_q.alu_op;
  assign reg_write_m  = exmem_q.reg_write;
  assign mem_write_m  = exmem_q.mem_write;
  assign result_src_m = exmem_q.result_src;
  assign reg_write_w  = memwb_q.reg_write;
  assign result_src_w = memwb_q.result_src;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: a full-featured instance (a) and one with jumps/upper
// disabled and a 2-bit counter (b) share one randomized stimulus stream.
module tb_ctrl_pipe;

  // Inputs change on the falling edge; the monitor samples 1 time unit after
  // the rising edge, so combinational outputs still reflect the driven inputs.
  localparam int RW = 12 + 4 + 3 + 8;  // e word, m, w, counter (zero-extended)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op_d = '0;
  logic       valid_d = 1'b0, stall_e = 1'b0, flush_e = 1'b0;

  logic [2:0] imm_a, imm_b;
  logic       ill_a, ill_b;
  logic       rwe_a, mwe_a, bre_a, jpe_a, jre_a, ase_a, rwm_a, mwm_a, rww_a;
  logic       rwe_b, mwe_b, bre_b, jpe_b, jre_b, ase_b, rwm_b, mwm_b, rww_b;
  logic [1:0] rse_a, aae_a, aoe_a, rsm_a, rsw_a;
  logic [1:0] rse_b, aae_b, aoe_b, rsm_b, rsw_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  ctrl_pipe u_dut_a (
    .clk(clk), .rst(rst), .op_d(op_d), .valid_d(valid_d), .stall_e(stall_e), .flush_e(flush_e),
    .imm_src_d(imm_a), .illegal_d(ill_a),
    .reg_write_e(rwe_a), .mem_write_e(mwe_a), .branch_e(bre_a), .jump_e(jpe_a), .jalr_e(jre_a),
    .alu_src_e(ase_a), .result_src_e(rse_a), .alu_a_src_e(aae_a), .alu_op_e(aoe_a),
    .reg_write_m(rwm_a), .mem_write_m(mwm_a), .result_src_m(rsm_a),
    .reg_write_w(rww_a), .result_src_w(rsw_a), .illegal_cnt(cnt_a)
  );

  ctrl_pipe #(.ENABLE_JUMP(1'b0), .ENABLE_UPPER(1'b0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .op_d(op_d), .valid_d(valid_d), .stall_e(stall_e), .flush_e(flush_e),
    .imm_src_d(imm_b), .illegal_d(ill_b),
    .reg_write_e(rwe_b), .mem_write_e(mwe_b), .branch_e(bre_b), .jump_e(jpe_b), .jalr_e(jre_b),
    .alu_src_e(ase_b), .result_src_e(rse_b), .alu_a_src_e(aae_b), .alu_op_e(aoe_b),
    .reg_write_m(rwm_b), .mem_write_m(mwm_b), .result_src_m(rsm_b),
    .reg_write_w(rww_b), .result_src_w(rsw_b), .illegal_cnt(cnt_b)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [11:0] w;      // {rw,mw,br,jp,jr,as,res[1:0],a_src[1:0],alu_op[1:0]}
    logic [2:0]  imm;
    logic        legal;
  } dec_t;

  function automatic dec_t ref_decode(input logic [6:0] op, input bit ej, input bit eu);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      7'b0000011: begin d.w = 12'b1000_0101_0000; d.imm = 3'd0; end // load
      7'b0100011: begin d.w = 12'b0100_0100_0000; d.imm = 3'd1; end // store
      7'b0110011: begin d.w = 12'b1000_0000_0010; d.imm = 3'd0; end // R
      7'b0010011: begin d.w = 12'b1000_0100_0010; d.imm = 3'd0; end // I-ALU
      7'b1100011: begin d.w = 12'b0010_0000_0001; d.imm = 3'd2; end // branch
      7'b1101111: begin d.w = 12'b1001_0010_0000; d.imm = 3'd3; d.legal = ej; end
      7'b1100111: begin d.w = 12'b1001_1110_0000; d.imm = 3'd0; d.legal = ej; end
      7'b0110111: begin d.w = 12'b1000_0100_1000; d.imm = 3'd4; d.legal = eu; end
      7'b0010111: begin d.w = 12'b1000_0100_0100; d.imm = 3'd4; d.legal = eu; end
      default:    d.legal = 1'b0;
    endcase
    if (!d.legal) d.w = '0;
    return d;
  endfunction

  logic [11:0] m_e[2];
  logic [3:0]  m_m[2];   // {reg_write, mem_write, result_src}
  logic [2:0]  m_w[2];   // {reg_write, result_src}
  int          m_cnt[2];
  int          cnt_max[2] = '{255, 3};
  bit          en_j[2] = '{1'b1, 1'b0};
  bit          en_u[2] = '{1'b1, 1'b0};

  typedef struct packed {
    logic       chk_imm;
    logic [2:0] imm;
    logic       ill;
  } comb_t;

  logic [RW-1:0] exp_q[2][$];
  comb_t         comb_q[2][$];

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  task automatic model_step(input int k);
    dec_t d;
    comb_t c;
    d = ref_decode(op_d, en_j[k], en_u[k]);
    c.chk_imm = valid_d && d.legal;
    c.imm     = d.imm;
    c.ill     = valid_d && !d.legal;
    comb_q[k].push_back(c);
    if (rst) begin
      m_e[k] = '0; m_m[k] = '0; m_w[k] = '0; m_cnt[k] = 0;
    end else begin
      m_w[k] = {m_m[k][3], m_m[k][1:0]};
      m_m[k] = (stall_e && !flush_e) ? 4'b0 : {m_e[k][11], m_e[k][10], m_e[k][5:4]};
      if (c.ill && !stall_e && !flush_e && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
      if (flush_e)       m_e[k] = '0;
      else if (!stall_e) m_e[k] = valid_d ? d.w : 12'b0;
    end
    exp_q[k].push_back({m_e[k], m_m[k], m_w[k], 8'(m_cnt[k])});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [6:0] op, input logic v, input logic st,
                       input logic fl, input logic r);
    @(negedge clk);
    op_d = op; valid_d = v; stall_e = st; flush_e = fl; rst = r;
    model_step(0);
    model_step(1);
  endtask

  logic [6:0] op_tab[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  function automatic logic [6:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 7'($urandom_range(0, 127));
    return op_tab[$urandom_range(0, 8)];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input logic [11:0] ae, input logic [3:0] am,
                           input logic [2:0] aw, input logic [7:0] ac,
                           input logic [2:0] aimm, input logic aill);
    logic [RW-1:0] e;
    comb_t c;
    e = exp_q[k].pop_front();
    c = comb_q[k].pop_front();
    check(k == 0 ? "a_e_word" : "b_e_word", 32'(ae), 32'(e[RW-1 -: 12]));
    check(k == 0 ? "a_m_word" : "b_m_word", 32'(am), 32'(e[14:11]));
    check(k == 0 ? "a_w_word" : "b_w_word", 32'(aw), 32'(e[10:8]));
    check(k == 0 ? "a_ill_cnt" : "b_ill_cnt", 32'(ac), 32'(e[7:0]));
    check(k == 0 ? "a_illegal_d" : "b_illegal_d", 32'(aill), 32'(c.ill));
    if (c.chk_imm) check(k == 0 ? "a_imm_src" : "b_imm_src", 32'(aimm), 32'(c.imm));
  endtask

  initial begin : monitor
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q[0].size() > 0) begin
        check_dut(0, {rwe_a, mwe_a, bre_a, jpe_a, jre_a, ase_a, rse_a, aae_a, aoe_a},
                  {rwm_a, mwm_a, rsm_a}, {rww_a, rsw_a}, cnt_a, imm_a, ill_a);
        check_dut(1, {rwe_b, mwe_b, bre_b, jpe_b, jre_b, ase_b, rse_b, aae_b, aoe_b},
                  {rwm_b, mwm_b, rsm_b}, {rww_b, rsw_b}, {6'b0, cnt_b}, imm_b, ill_b);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int guard;
    for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    // every opcode straight through, then drain
    for (int i = 0; i < 9; i++) drive(op_tab[i], 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    // load held under a two-cycle stall
    drive(7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b0110011, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(7'b0110011, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0);
    // flush beats stall; prior E word still moves to M
    drive(7'b0100011, 1'b1, 1'b1, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    // illegal opcodes: counter saturation in the narrow instance, stall gating
    for (int i = 0; i < 5; i++) drive(7'b1111111, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b1111111, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(7'b1101111, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b0110111, 1'b1, 1'b0, 1'b0, 1'b0);
    // mid-stream reset
    drive(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b0100011, 1'b1, 1'b0, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    // random traffic with occasional reset
    for (int i = 0; i < 2000; i++)
      drive(rand_op(), 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 40) == 0));
    // long illegal-heavy run without reset to saturate the wide counter
    for (int i = 0; i < 700; i++)
      drive(($urandom_range(0, 3) == 0) ? rand_op() : 7'b0000000, 1'b1,
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0), 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (exp_q[0].size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q[0].size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q[0].size());
    end
    done = 1'b1;
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the RISC-V pipelined core: decodes the 7-bit opcode in Decode, then carries the control word through the ID/EX, EX/MEM and MEM/WB control registers, honouring hazard-unit stall and flush requests. It replaces the flat opcode decoder. It adds JAL/JALR and LUI/AUIPC under parameter control, a wider immediate/result encoding, illegal-opcode detection, and a saturating illegal-instruction counter.

## Interface
- ENABLE_JUMP, 1, decode JAL (1101111) and JALR (1100111); 0 makes them illegal
- ENABLE_UPPER, 1, decode LUI (0110111) and AUIPC (0010111); 0 makes them illegal
- CNT_W, 8, illegal-counter width (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- op_d  in  7  opcode of instruction in Decode
- valid_d  in  1  Decode holds a real instruction
- stall_e  in  1  hold ID/EX, bubble into EX/MEM
- flush_e  in  1  bubble into ID/EX
- imm_src_d  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational)
- illegal_d  out  1  valid_d and opcode not decoded (combinational)
- reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e  out  1 each  EX-stage controls
- result_src_e  out  2  00 ALU, 01 memory, 10 PC+4
- alu_a_src_e  out  2  00 rs1, 01 PC, 10 zero
- alu_op_e  out  2  00 add, 01 sub (branch), 10 funct-decoded
- reg_write_m, mem_write_m  out  1 each; result_src_m  out  2
- reg_write_w  out  1; result_src_w  out  2
- illegal_cnt  out  CNT_W  saturating count of illegal instructions entering EX

## Operation
- Decode (fields not listed are 0; alu_a_src 00 unless stated):
  - load 0000011: reg_write, alu_src, result_src=01, imm I
  - store 0100011: mem_write, alu_src, imm S
  - R 0110011: reg_write, alu_op=10
  - I-ALU 0010011: reg_write, alu_src, alu_op=10, imm I
  - branch 1100011: branch, alu_op=01, imm B
  - JAL: reg_write, jump, result_src=10, imm J
  - JALR: reg_write, jump, jalr, alu_src, result_src=10, imm I
  - LUI: reg_write, alu_src, alu_a_src=10, imm U
  - AUIPC: reg_write, alu_src, alu_a_src=01, imm U
- Any other opcode, or a disabled one: all-zero control word (a bubble), illegal_d=1 if valid_d.
- valid_d=0: the control word presented to ID/EX is all-zero; illegal_d=0.
- ID/EX update priority: rst > flush_e (load zero) > stall_e (hold) > load the decoded word.
- EX/MEM: loads zero when stall_e=1 and flush_e=0, otherwise loads the ID/EX M/W fields.
- MEM/WB always advances.
- illegal_cnt increments when illegal_d=1 and ID/EX loads, i.e. flush_e=0 and stall_e=0. It saturates at 2^CNT_W−1 and never wraps.

## Timing
- Decode outputs are combinational from op_d/valid_d in the same cycle.
- Latency: the D-cycle word appears on *_e one cycle later, *_m two cycles later, *_w three cycles later (absent stall/flush).
- A stall holds *_e for as many cycles as stall_e is asserted. Each stalled cycle inserts one bubble downstream.
- Flush and stall in the same cycle: flush wins, ID/EX=0, EX/MEM loads the old ID/EX contents.
- Reset: every registered output and illegal_cnt are 0 the cycle after rst. rst mid-stream discards all in-flight control words.

## Structure
- Package riscv_ctrl_pkg holds:
  - opcode constants
  - imm_src, result_src, alu_a_src and alu_op encodings
  - a packed ctrl_word_t struct (ID/EX contents)
  - the CNT_W default
- Sub-module ctrl_decode is purely combinational: op, valid, and the two enables in; ctrl_word_t, imm_src and illegal out.
- ctrl_pipe holds the three pipeline registers and the counter.

## Test plan
- Reset, then each of the 9 opcodes with valid_d=1, no stall/flush → *_e matches the decode list one cycle later, *_m after two, *_w after three; illegal_cnt=0.
- ENABLE_JUMP=0, op_d=1101111 → illegal_d=1, *_e all zero, illegal_cnt=1. ENABLE_UPPER=0 with op_d=0110111 → same result.
- Load into E, stall_e=1 for 2 cycles → result_src_e=01 held for 3 cycles; result_src_m=00 during the two bubbles, then 01.
- flush_e=1 and stall_e=1 with op_d=0100011 → mem_write_e=0 next cycle; the prior E word still reaches M.
- CNT_W=2, five illegal opcodes → illegal_cnt goes 1, 2, 3, 3, 3. Illegal op under stall_e → no increment.
- Stream R, load, store, then rst asserted mid-stream → all *_e/*_m/*_w and illegal_cnt read 0 the next cycle.
